// File: rtl/backup_input_packer.sv
// Packs a stream of signed feature beats into one FIFO word per kernel row,
// tagging each word with its row id for the backup-input sender.
module backup_input_packer #(
    parameter int FEAT_W     = 8,
    parameter int BEAT_FEATS = 4,
    parameter int MEM_WIDTH  = 16,
    parameter int MAX_K      = 3,
    parameter int WIDTH_W    = 8
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic                           start,
    input  logic [WIDTH_W-1:0]             cfg_width,
    input  logic [$clog2(MAX_K+1)-1:0]     cfg_rows,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [BEAT_FEATS*FEAT_W-1:0]   in_data,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [MEM_WIDTH*FEAT_W-1:0]    fifo_data,
    output logic [$clog2(MAX_K)-1:0]       row_id,
    output logic                           busy,
    output logic                           done
);

    localparam int RCFG_W    = $clog2(MAX_K + 1);
    localparam int ROW_W     = $clog2(MAX_K);
    localparam int MAX_BEATS = MEM_WIDTH / BEAT_FEATS;
    localparam int BCNT_W    = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [WIDTH_W-1:0] clamp_width(input logic [WIDTH_W-1:0] w);
        if (w > WIDTH_W'(MEM_WIDTH))
            return WIDTH_W'(MEM_WIDTH);
        return w;
    endfunction

    function automatic logic [RCFG_W-1:0] clamp_rows(input logic [RCFG_W-1:0] r);
        if (r == '0)
            return RCFG_W'(1);
        if (r > RCFG_W'(MAX_K))
            return RCFG_W'(MAX_K);
        return r;
    endfunction

    function automatic logic [BCNT_W-1:0] beats_for(input logic [WIDTH_W-1:0] w);
        logic [WIDTH_W:0] sum;
        sum = {1'b0, w} + (WIDTH_W+1)'(BEAT_FEATS - 1);
        return BCNT_W'(sum / (WIDTH_W+1)'(BEAT_FEATS));
    endfunction

    logic [1:0]               state;
    logic [WIDTH_W-1:0]       width_q;
    logic [RCFG_W-1:0]        rows_q;
    logic [BCNT_W-1:0]        beats_q;
    logic [BCNT_W-1:0]        beat_cnt;
    logic [ROW_W-1:0]         row_q;
    logic signed [FEAT_W-1:0] pack_buf [MEM_WIDTH];
    logic signed [FEAT_W-1:0] lane [BEAT_FEATS];

    logic [WIDTH_W-1:0] start_width;
    logic [RCFG_W-1:0]  start_rows;
    logic [BCNT_W-1:0]  start_beats;
    logic               beat_fire;
    logic               last_beat;
    logic               push_fire;
    logic               last_row;
    logic               buf_clear;

    assign start_width = clamp_width(cfg_width);
    assign start_rows  = clamp_rows(cfg_rows);
    assign start_beats = beats_for(start_width);

    assign beat_fire = (state == S_FILL) && in_valid;
    assign last_beat = (beat_cnt == beats_q - BCNT_W'(1));
    assign push_fire = (state == S_PUSH) && !fifo_full;
    assign last_row  = ((RCFG_W'(row_q) + RCFG_W'(1)) == rows_q);
    assign buf_clear = ((state == S_IDLE) && start) || (push_fire && !last_row);

    for (genvar l = 0; l < BEAT_FEATS; l++) begin : g_lane
        assign lane[l] = in_data[l*FEAT_W +: FEAT_W];
    end

    for (genvar s = 0; s < MEM_WIDTH; s++) begin : g_pack
        assign fifo_data[s*FEAT_W +: FEAT_W] = pack_buf[s];
    end

    assign in_ready   = (state == S_FILL);
    assign fifo_wr_en = push_fire;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign row_id     = row_q;

    // Packing buffer: each beat lands in its column window; columns past width stay zero.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < MEM_WIDTH; s++)
                pack_buf[s] <= '0;
        end else if (buf_clear) begin
            for (int s = 0; s < MEM_WIDTH; s++)
                pack_buf[s] <= '0;
        end else if (beat_fire) begin
            for (int s = 0; s < MEM_WIDTH; s++) begin
                if (BCNT_W'(s / BEAT_FEATS) == beat_cnt)
                    pack_buf[s] <= (WIDTH_W'(s) < width_q) ? lane[s % BEAT_FEATS] : '0;
            end
        end
    end

    // Batch sequencing: a zero-width row skips FILL entirely and pushes a zero word.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            width_q  <= '0;
            rows_q   <= '0;
            beats_q  <= '0;
            beat_cnt <= '0;
            row_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_q  <= start_width;
                        rows_q   <= start_rows;
                        beats_q  <= start_beats;
                        beat_cnt <= '0;
                        row_q    <= '0;
                        state    <= (start_width == '0) ? S_PUSH : S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + BCNT_W'(1);
                        if (last_beat)
                            state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (!fifo_full) begin
                        if (last_row) begin
                            state <= S_DONE;
                        end else begin
                            row_q    <= row_q + ROW_W'(1);
                            beat_cnt <= '0;
                            state    <= (width_q == '0) ? S_PUSH : S_FILL;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
